seg_scan_driver: RTL

//   Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits.

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/seg_hex_decoder.sv | 19 +
 rtl/seg_scan_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared types and constants for the 7-segment scan driver.
//   seg_t bit order is {a,b,c,d,e,f,g,dp}, MSB = segment a.
//   hex2seg() maps a hex nibble to its logical (active-high) segment pattern,
//   with the decimal point bit cleared.
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_e;

  localparam seg_t SEG_0   = 8'hFC;
  localparam seg_t SEG_1   = 8'h60;
  localparam seg_t SEG_2   = 8'hDA;
  localparam seg_t SEG_3   = 8'hF2;
  localparam seg_t SEG_4   = 8'h66;
  localparam seg_t SEG_5   = 8'hB6;
  localparam seg_t SEG_6   = 8'hBE;
  localparam seg_t SEG_7   = 8'hE0;
  localparam seg_t SEG_8   = 8'hFE;
  localparam seg_t SEG_9   = 8'hF6;
  localparam seg_t SEG_A   = 8'hEE;
  localparam seg_t SEG_B   = 8'h3E;
  localparam seg_t SEG_C   = 8'h9C;
  localparam seg_t SEG_D   = 8'h7A;
  localparam seg_t SEG_E   = 8'h9E;
  localparam seg_t SEG_F   = 8'h8E;
  localparam seg_t SEG_OFF = 8'h00;

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    seg_t s;
    case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
//   Combinational hex nibble + decimal point -> logical segment pattern.
//   Ports:
//     nibble_i  in   4  hex digit value
//     dp_i      in   1  decimal point, ORed into bit 0
//     seg_o     out  8  {a,b,c,d,e,f,g,dp}, active-high
// -----------------------------------------------------------------------------
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = hex2seg(nibble_i) | {7'b0, dp_i};

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for NUM_DIGITS 7-segment digits. Each digit slot is
//   SCAN_DIV clocks: GUARD_CYC clocks fully dark (ghosting guard), then the
//   digit is lit for the rest of the slot. Frame updates are double-buffered:
//   an accepted update waits in a pending register and is copied to the
//   displayed frame only at frame wrap, so a frame is never shown half-updated.
//   Ports:
//     clk        in   1             system clock
//     rst_n      in   1             asynchronous active-low reset
//     upd_valid  in   1             frame update request
//     upd_ready  out  1             pending buffer empty
//     upd_hex    in   4*NUM_DIGITS  nibbles, [3:0] = digit 0 (rightmost)
//     upd_dp     in   NUM_DIGITS    decimal point per digit
//     upd_blank  in   NUM_DIGITS    force digit dark
//     upd_lzb    in   1             leading-zero blanking enable
//     seg_o      out  8             {a..g,dp} at pin polarity
//     dig_o      out  NUM_DIGITS    one-hot digit enable at pin polarity
//     frame_o    out  1             one-cycle pulse when a new frame commits
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_hex,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blank,
  input  logic                    upd_lzb,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_LAST = PRE_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q;
  logic [PRE_W-1:0]        pre_q;
  logic [IDX_W-1:0]        idx_q;

  logic [4*NUM_DIGITS-1:0] act_hex_q,   pend_hex_q;
  logic [NUM_DIGITS-1:0]   act_dp_q,    pend_dp_q;
  logic [NUM_DIGITS-1:0]   act_blank_q, pend_blank_q;
  logic                    act_lzb_q,   pend_lzb_q;
  logic                    pend_full_q;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q;

  logic                    slot_end, frame_wrap, commit, xfer, show;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   hi_zero;
  logic                    hz_acc;
  logic                    lz_blank;
  logic [7:0]              dec_seg;

  assign upd_ready  = !pend_full_q;
  assign xfer       = upd_valid && upd_ready;
  assign slot_end   = (pre_q == PRE_LAST);
  assign frame_wrap = slot_end && (idx_q == IDX_LAST);
  // Only a full pending buffer produces a commit (and a frame_o pulse).
  assign commit     = frame_wrap && pend_full_q;
  // With no guard the GUARD state only exists for the first cycle after reset;
  // treat it as lit so the display has no gap at all.
  assign show       = (state_q == ST_SCAN) || (GUARD_CYC == 0);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = act_hex_q[gi*4 +: 4];
  end

  // hi_zero[i]: nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    hi_zero = '0;
    hz_acc  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hz_acc     = hz_acc && (nib[i] == 4'h0);
      hi_zero[i] = hz_acc;
    end
  end

  assign lz_blank = act_lzb_q && (idx_q != '0) && hi_zero[idx_q];

  seg_hex_decoder u_dec (
    .nibble_i (nib[idx_q]),
    .dp_i     (act_dp_q[idx_q]),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dig_d = '0;
    if (show) begin
      dig_d = NUM_DIGITS'(1) << idx_q;
      if (act_blank_q[idx_q])
        seg_d = SEG_OFF;
      else if (lz_blank)
        seg_d = {7'b0, act_dp_q[idx_q]};   // dp survives leading-zero blanking
      else
        seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GUARD;
      pre_q        <= '0;
      idx_q        <= '0;
      act_hex_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      act_lzb_q    <= 1'b0;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_lzb_q   <= 1'b0;
      pend_full_q  <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= '0;
      frame_q      <= 1'b0;
    end else begin
      pre_q <= slot_end ? '0 : pre_q + PRE_W'(1);
      if (slot_end)
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

      case (state_q)
        ST_GUARD: if ((GUARD_CYC == 0) || (pre_q == GUARD_LAST)) state_q <= ST_SCAN;
        default:  if (slot_end) state_q <= (GUARD_CYC == 0) ? ST_SCAN : ST_GUARD;
      endcase

      // xfer needs an empty buffer and commit a full one, so they never collide.
      if (xfer) begin
        pend_hex_q   <= upd_hex;
        pend_dp_q    <= upd_dp;
        pend_blank_q <= upd_blank;
        pend_lzb_q   <= upd_lzb;
        pend_full_q  <= 1'b1;
      end else if (commit) begin
        pend_full_q  <= 1'b0;
      end

      if (commit) begin
        act_hex_q   <= pend_hex_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
        act_lzb_q   <= pend_lzb_q;
      end

      frame_q <= commit;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg_o   = seg_q ^ {8{SEG_ACT_LOW}};
  assign dig_o   = dig_q ^ {NUM_DIGITS{DIG_ACT_LOW}};
  assign frame_o = frame_q;

endmodule
